// File: rtl/issue_pkg.sv
// Shared opcode constants, the issued-instruction bundle and the destination-latency rules.
// Latency and backpressure: not applicable, declarations only.
package issue_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_FPU = 6'b010001;

    typedef struct packed {
        logic [31:0]      instr;
        logic [5:0]       opecode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } instr_t;

    function automatic logic writes_rd(input logic [5:0] opecode);
        return !(opecode inside {OP_BEQ, OP_BNE, OP_SW, OP_J});
    endfunction

    // ALU results are forwarded, so only long-latency producers need bubbles.
    function automatic int unsigned dest_lat(input logic [5:0] opecode,
                                             input int unsigned load_lat,
                                             input int unsigned fpu_lat);
        case (opecode)
            OP_LW:   return load_lat;
            OP_FPU:  return fpu_lat;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register bubble counters with three combinational hazard lookups.
// Lookup is same-cycle; counters freeze while adv is low (execute backpressure).
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             adv,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic [CNT_W-1:0] set_val,
    input  logic [REG_W-1:0] rs_idx,
    input  logic [REG_W-1:0] rt_idx,
    input  logic [REG_W-1:0] rd_idx,
    input  logic             rd_chk,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (adv && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        // A fresh load overrides the decrement of the same register; r0 is never tracked.
        if (set_en && set_idx != '0) begin
            cnt_d[set_idx] = set_val;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        if (rs_idx != '0 && cnt_q[rs_idx] != '0) hit = 1'b1;
        if (rt_idx != '0 && cnt_q[rt_idx] != '0) hit = 1'b1;
        if (rd_chk && rd_idx != '0 && cnt_q[rd_idx] != '0) hit = 1'b1;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Issue stage: hazard interlock against the scoreboard, one-entry issue register, flush, stall counter.
// Issue latency 1 cycle; holds while iss_ready is low, in_ready drops on hazard, flush or a full stalled register.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int FPU_LAT  = 3,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [5:0]       in_opecode,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] in_rs,
    input  logic [REG_W-1:0] in_rt,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [31:0]      iss_instr,
    output logic [5:0]       iss_opecode,
    output logic [REG_W-1:0] iss_rd,
    output logic [REG_W-1:0] iss_rs,
    output logic [REG_W-1:0] iss_rt,
    output logic [31:0]      stall_cnt
);

    logic             iss_vld_q, iss_vld_d;
    instr_t           iss_q, iss_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             in_wr;
    logic [CNT_W-1:0] in_lat;
    logic             sb_hit;
    logic             hazard;
    logic             adv;
    logic             accept;

    assign in_wr  = writes_rd(in_opecode);
    assign in_lat = CNT_W'(dest_lat(in_opecode, LOAD_LAT, FPU_LAT));
    assign hazard = in_valid && sb_hit;
    assign adv    = !iss_vld_q || iss_ready;
    assign in_ready = rstn && !hazard && !flush && adv;
    assign accept = in_valid && in_ready;

    issue_scoreboard #(
        .CNT_W (CNT_W)
    ) u_sb (
        .clk     (clk),
        .rstn    (rstn),
        .adv     (adv),
        .set_en  (accept && in_wr && in_lat != '0),
        .set_idx (in_rd),
        .set_val (in_lat),
        .rs_idx  (in_rs),
        .rt_idx  (in_rt),
        .rd_idx  (in_rd),
        .rd_chk  (in_wr),
        .hit     (sb_hit)
    );

    always_comb begin
        iss_vld_d   = iss_vld_q;
        iss_d       = iss_q;
        stall_cnt_d = stall_cnt_q;
        // Flush outranks both a new accept and a stalled hold.
        if (flush) begin
            iss_vld_d = 1'b0;
        end else if (accept) begin
            iss_vld_d = 1'b1;
            iss_d     = '{instr: in_instr, opecode: in_opecode, rd: in_rd, rs: in_rs, rt: in_rt};
        end else if (iss_ready) begin
            iss_vld_d = 1'b0;
        end
        if (hazard && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            iss_vld_q   <= 1'b0;
            iss_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            iss_vld_q   <= iss_vld_d;
            iss_q       <= iss_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss_valid   = iss_vld_q;
    assign iss_instr   = iss_q.instr;
    assign iss_opecode = iss_q.opecode;
    assign iss_rd      = iss_q.rd;
    assign iss_rs      = iss_q.rs;
    assign iss_rt      = iss_q.rt;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed hazard scenarios plus randomized traffic against a cycle model.
module tb_issue_scheduler;

    localparam int LOAD_LAT = 2;
    localparam int FPU_LAT  = 3;
    localparam logic [5:0] ALU = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] FPU = 6'b010001;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [5:0]  in_opecode = '0;
    logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b1;
    logic [31:0] iss_instr;
    logic [5:0]  iss_opecode;
    logic [4:0]  iss_rd, iss_rs, iss_rt;
    logic [31:0] stall_cnt;

    issue_scheduler #(.LOAD_LAT(LOAD_LAT), .FPU_LAT(FPU_LAT), .CNT_W(3)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_opecode(in_opecode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
        .iss_opecode(iss_opecode), .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: remaining bubbles per register, issue slot contents, stall total.
    int          m_cnt [32];
    bit          m_vld;
    logic [52:0] m_dat;
    longint      m_stall;
    bit          last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_wr(input logic [5:0] op);
        return !(op == 6'b000100 || op == 6'b000101 || op == 6'b101011 || op == 6'b000010);
    endfunction

    function automatic int ref_lat(input logic [5:0] op);
        if (op == 6'b100011) return LOAD_LAT;
        if (op == 6'b010001) return FPU_LAT;
        return 0;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_vld   = 1'b0;
        m_dat   = '0;
        m_stall = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, advance the model.
    task automatic cycle(input bit v, input logic [31:0] w, input logic [5:0] op,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input bit rdy, input bit fl);
        bit haz, adv, exp_rdy;
        @(negedge clk);
        check("iss_valid", {63'd0, iss_valid}, {63'd0, m_vld});
        if (m_vld) check("iss_data", {11'd0, iss_instr, iss_opecode, iss_rd, iss_rs, iss_rt}, {11'd0, m_dat});
        check("stall_cnt", {32'd0, stall_cnt}, m_stall);
        in_valid = v; in_instr = w; in_opecode = op;
        in_rd = rd; in_rs = rs; in_rt = rt;
        iss_ready = rdy; flush = fl;
        #1;
        haz = v && ((rs != 0 && m_cnt[rs] != 0) || (rt != 0 && m_cnt[rt] != 0) ||
                    (ref_wr(op) && rd != 0 && m_cnt[rd] != 0));
        adv = !m_vld || rdy;
        exp_rdy = !haz && !fl && adv;
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        last_acc = v && exp_rdy;
        if (adv) foreach (m_cnt[i]) if (m_cnt[i] > 0) m_cnt[i]--;
        if (last_acc && ref_wr(op) && rd != 0 && ref_lat(op) > 0) m_cnt[rd] = ref_lat(op);
        if (haz && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (fl) m_vld = 1'b0;
        else if (last_acc) begin
            m_vld = 1'b1;
            m_dat = {w, op, rd, rs, rt};
        end else if (rdy) m_vld = 1'b0;
    endtask

    // Holds one instruction with iss_ready high until accepted; tries counts attempted cycles.
    task automatic issue_until(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                               input logic [4:0] rt, output int tries);
        logic [31:0] w;
        w = $urandom;
        tries = 0;
        do begin
            cycle(1'b1, w, op, rd, rs, rt, 1'b1, 1'b0);
            tries++;
        end while (!last_acc && tries < 20);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, ALU, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    endtask

    logic [5:0]  ops [7];
    bit          hv;
    logic [31:0] hw;
    logic [5:0]  hop;
    logic [4:0]  hrd, hrs, hrt;
    int          t;
    logic [31:0] w9;

    initial begin
        ops = '{ALU, ALU, LW, FPU, BEQ, 6'b000101, SW};
        model_reset();
        in_valid = 1'b1; in_opecode = ALU; in_rd = 5'd1; in_rs = 5'd2; in_rt = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iss_valid", {63'd0, iss_valid}, 64'd0);
        check("rst_stall", {32'd0, stall_cnt}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_iss_instr", {32'd0, iss_instr}, 64'd0);
        in_valid = 1'b0;
        rstn = 1'b1;

        // Back-to-back ALU dependency is forwarded, no bubbles.
        issue_until(ALU, 5'd3, 5'd1, 5'd2, t);  check("alu_first", t, 1);
        issue_until(ALU, 5'd4, 5'd3, 5'd3, t);  check("alu_b2b", t, 1);

        issue_until(LW, 5'd5, 5'd2, 5'd0, t);
        issue_until(ALU, 5'd6, 5'd5, 5'd1, t);  check("load_use_tries", t, 3);
        idle(1);
        check("load_use_stall", {32'd0, stall_cnt}, 64'd2);

        // Execute stage stalls: counters freeze, issue register holds.
        issue_until(LW, 5'd7, 5'd1, 5'd0, t);
        w9 = $urandom;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, w9, ALU, 5'd8, 5'd7, 5'd7, 1'b0, 1'b0);
            check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        end
        issue_until(ALU, 5'd8, 5'd7, 5'd7, t);  check("bp_release_tries", t, 3);

        issue_until(LW, 5'd5, 5'd1, 5'd0, t);
        issue_until(SW, 5'd0, 5'd1, 5'd5, t);   check("sw_after_lw", t, 3);
        issue_until(LW, 5'd0, 5'd1, 5'd0, t);
        issue_until(ALU, 5'd10, 5'd0, 5'd0, t); check("r0_no_hazard", t, 1);
        issue_until(BEQ, 5'd8, 5'd1, 5'd2, t);
        issue_until(ALU, 5'd11, 5'd8, 5'd8, t); check("beq_no_set", t, 1);

        // Flush against a held, stalled issue register with a new instruction offered.
        idle(4);
        issue_until(ALU, 5'd12, 5'd1, 5'd2, t);
        w9 = $urandom;
        cycle(1'b1, w9, ALU, 5'd13, 5'd1, 5'd2, 1'b0, 1'b0);
        cycle(1'b1, w9, ALU, 5'd13, 5'd1, 5'd2, 1'b0, 1'b1);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        idle(1);
        check("flush_clear", {63'd0, iss_valid}, 64'd0);

        // Asynchronous reset between edges while a dependent waits on an FPU result.
        issue_until(FPU, 5'd9, 5'd1, 5'd2, t);
        w9 = $urandom;
        cycle(1'b1, w9, ALU, 5'd14, 5'd9, 5'd1, 1'b0, 1'b0);
        check("fpu_stall_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_iss_valid", {63'd0, iss_valid}, 64'd0);
        check("arst_stall", {32'd0, stall_cnt}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd0);
        model_reset();
        #1;
        rstn = 1'b1;
        issue_until(ALU, 5'd14, 5'd9, 5'd1, t); check("arst_dep_tries", t, 1);

        // Random traffic; an offered instruction is held until accepted.
        hv = 1'b0; hw = '0; hop = ALU; hrd = '0; hrs = '0; hrt = '0;
        last_acc = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!(hv && !last_acc)) begin
                hv  = ($urandom_range(0, 9) < 7);
                hw  = $urandom;
                hop = ops[$urandom_range(0, 6)];
                hrd = 5'($urandom_range(0, 7));
                hrs = 5'($urandom_range(0, 7));
                hrt = 5'($urandom_range(0, 7));
            end
            cycle(hv, hw, hop, hrd, hrs, hrt, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue-stage controller between the instruction decoder and the execute stage of the core.
- Accepts decoded instructions over valid/ready and interlocks on register hazards with a per-register latency scoreboard.
- Issues hazard-free instructions through a one-entry output register with valid/ready handshake.
- Supports a pipeline flush from branch resolution.

Parameters:
- LOAD_LAT, 2, bubble cycles a dependent instruction must wait after a load (opecode 100011).
- FPU_LAT, 3, bubble cycles a dependent instruction must wait after an FPU op (opecode 010001).
- CNT_W, 3, scoreboard counter width; must hold max(LOAD_LAT, FPU_LAT).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  squash the issue register this cycle.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  scheduler accepts this cycle.
- in_instr  in  32  raw instruction word, passed through.
- in_opecode  in  6  decoded opcode.
- in_rd  in  5  destination register field.
- in_rs  in  5  source register field.
- in_rt  in  5  source register field.
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  execute stage accepts.
- iss_instr  out  32  issued instruction word.
- iss_opecode  out  6  issued opcode.
- iss_rd  out  5  issued destination field.
- iss_rs  out  5  issued source field.
- iss_rt  out  5  issued source field.
- stall_cnt  out  32  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rstn low, async):
  - iss_valid=0; all iss_* data outputs=0; stall_cnt=0; all 32 scoreboard counters=0.
  - in_ready stays combinational but evaluates 0 while reset is asserted.
  - Reset mid-operation discards the held instruction and all pending latencies.
- writes_rd is true unless opecode is in {000100 beq, 000101 bne, 101011 sw, 000010 j}.
- Destination latency lat = LOAD_LAT for 100011, FPU_LAT for 010001, otherwise 0 (forwarded ALU result).
- Register 0 never raises a hazard and is never written into the scoreboard.
- Hazard is true when in_valid and any of the following holds:
  - in_rs≠0 and cnt[in_rs]≠0.
  - in_rt≠0 and cnt[in_rt]≠0.
  - writes_rd, in_rd≠0 and cnt[in_rd]≠0 (conservative WAW).
- Both sources are always checked for opcode j as well; this is conservative and accepted.
- in_ready = !hazard && !flush && (!iss_valid || iss_ready). It is combinational on the input fields, so the decoder must hold its fields stable while in_valid is high.
- Accept = in_valid && in_ready. On accept the issue register loads all in_* fields and iss_valid=1 at the next edge; issue latency is 1 cycle.
- If iss_valid && iss_ready && !accept, iss_valid clears. If iss_valid && !iss_ready, the issue register and outputs hold unchanged.
- Scoreboard advance condition: adv = !iss_valid || iss_ready.
  - When adv is true, every nonzero counter decrements by 1.
  - When adv is false, all counters freeze, because the execute stage is backpressuring.
- On accept with writes_rd, in_rd≠0 and lat≠0: cnt[in_rd] is loaded with lat. The load wins over a simultaneous decrement of the same counter.
- Resulting timing with no backpressure: a dependent instruction is accepted exactly lat+1 cycles after its producer's accept edge, i.e. lat bubbles.
- flush high:
  - iss_valid clears at the next edge and in_ready=0 that cycle.
  - Counters keep decrementing per the adv rule; counters set by squashed instructions are not cleared (conservative, performance-only).
  - flush has priority over accept and over iss_ready hold.
- stall_cnt increments each cycle in_valid && hazard, and saturates at 32'hFFFFFFFF.

Decomposition:
- Shared package (issue_pkg) holds:
  - Opcode constants OP_BEQ, OP_BNE, OP_SW, OP_J, OP_LW, OP_FPU.
  - Functions writes_rd(opecode) and dest_lat(opecode).
  - Register-index width (5).
- One sub-module, issue_scoreboard, covers the 32×CNT_W counters, the decrement/load logic and the three-port hazard lookup. issue_scheduler keeps the handshake, issue register, flush and stall_cnt.

Test Plan:
- Reset then ALU stream: add r3←r1,r2 followed by add r4←r3,r3, in_valid held, iss_ready=1 → accepted back-to-back, iss_valid high on consecutive cycles, stall_cnt=0.
- Load-use: lw r5 (100011) then add r6←r5,r1, LOAD_LAT=2 → dependent accepted 3 cycles after lw accept, in_ready low 2 cycles, stall_cnt=2.
- Backpressure freeze: lw r7, then hold iss_ready=0 for 4 cycles with dependent pending → cnt[7] stays 2 and outputs stay stable; after release the dependent issues 3 cycles later.
- Store/branch/r0: sw using r5 right after lw r5 stalls 2 cycles; lw r0 then add using r0 → no stall; beq does not set any counter.
- Flush priority: iss_valid=1 with iss_ready=0, assert flush together with in_valid → iss_valid=0 next cycle, the input is not accepted, and in_ready=0 during the flush cycle.
- Async reset mid-stall: after FPU op on r9 (cnt=3), pulse rstn low between edges → iss_valid=0, stall_cnt=0, a dependent on r9 is accepted on the first edge after release.
